// File: rtl/stim_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// stim_sequencer_pkg
// Shared types and default sizes for the table-driven stimulus player.
//   - Default widths/depth used by the sequencer, its interface and table.
//   - state_e : playback state machine encoding.
//   - step_t  : one table entry {hold delay, active-low controls, switch word}
//               at the default widths.
//   - makeStep: convenience constructor for a default-width step.
// ---------------------------------------------------------------------------
package stim_sequencer_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int DEPTH_DEF    = 16;
    localparam int DELAY_W_DEF  = 8;
    localparam int NUM_CTRL_DEF = 3;

    // IDLE accepts table writes and start requests, PLAY replays entries,
    // DONE is the single-cycle completion state that drives the done pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Packed so the table can store it as a flat word: the hold count sits in
    // the top bits, the switch word in the bottom bits.
    typedef struct packed {
        logic [DELAY_W_DEF-1:0]  delay;
        logic [NUM_CTRL_DEF-1:0] ctrl;
        logic [DATA_W_DEF-1:0]   data;
    } step_t;

    localparam int STEP_W_DEF = $bits(step_t);

    // Builds a step from its three fields in table-word order.
    function automatic step_t makeStep(
        input logic [DELAY_W_DEF-1:0]  delay,
        input logic [NUM_CTRL_DEF-1:0] ctrl,
        input logic [DATA_W_DEF-1:0]   data
    );
        step_t s;
        s.delay = delay;
        s.ctrl  = ctrl;
        s.data  = data;
        return s;
    endfunction

endpackage

// File: rtl/stim_sequencer_if.sv
// ---------------------------------------------------------------------------
// stim_sequencer_if
// Bundles the table-load, playback-control and output signals of the
// stimulus sequencer. Clock and reset stay as plain ports on the modules.
//   master : the side that loads the table and requests playback
//            (drives wr_*, len, loop, start, abort; observes outputs)
//   slave  : the sequencer itself
// Signals:
//   wr_en/wr_addr/wr_delay/wr_ctrl/wr_data : table entry write
//   len/loop/start/abort                   : playback control
//   ctrl_n/data_out/step_idx               : replayed controls and switch word
//   busy/done/wr_err                       : status
// ---------------------------------------------------------------------------
interface stim_sequencer_if
    import stim_sequencer_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int DELAY_W  = DELAY_W_DEF,
    parameter int NUM_CTRL = NUM_CTRL_DEF
);

    localparam int AW = $clog2(DEPTH);

    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [DELAY_W-1:0]  wr_delay;
    logic [NUM_CTRL-1:0] wr_ctrl;
    logic [DATA_W-1:0]   wr_data;
    logic [AW:0]         len;
    logic                loop;
    logic                start;
    logic                abort;

    logic [NUM_CTRL-1:0] ctrl_n;
    logic [DATA_W-1:0]   data_out;
    logic [AW-1:0]       step_idx;
    logic                busy;
    logic                done;
    logic                wr_err;

    modport master (
        output wr_en, wr_addr, wr_delay, wr_ctrl, wr_data,
        output len, loop, start, abort,
        input  ctrl_n, data_out, step_idx, busy, done, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_delay, wr_ctrl, wr_data,
        input  len, loop, start, abort,
        output ctrl_n, data_out, step_idx, busy, done, wr_err
    );

endinterface

// File: rtl/stim_sequencer_table.sv
// ---------------------------------------------------------------------------
// stim_sequencer_table
// DEPTH x WIDTH register file holding the playback steps.
// Ports:
//   i_clk    : clock, write happens on the rising edge
//   i_we     : write enable
//   i_wrAddr : write index
//   i_wrWord : packed step {delay, ctrl, data}
//   i_rdAddr : read index (combinational read)
//   o_rdWord : packed step stored at i_rdAddr
// The contents are deliberately not reset so a loaded script survives a
// board reset and the storage maps onto plain flops or distributed RAM.
// ---------------------------------------------------------------------------
module stim_sequencer_table #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 27,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_wrAddr,
    input  logic [WIDTH-1:0] i_wrWord,
    input  logic [AW-1:0]    i_rdAddr,
    output logic [WIDTH-1:0] o_rdWord
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Single synchronous write port; a write becomes visible on the read
    // port from the following cycle.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wrAddr] <= i_wrWord;
        end
    end

    // Asynchronous read so the sequencer can look up the next entry in the
    // same cycle it decides to advance.
    assign o_rdWord = r_mem[i_rdAddr];

endmodule

// File: rtl/stim_sequencer.sv
// ---------------------------------------------------------------------------
// stim_sequencer
// Table-driven stimulus player for the processor top level. Replays a loaded
// list of {hold time, active-low control bits, switch word} steps onto the
// Reset/Run/Continue-style controls and the S switch bus, optionally looping.
// Ports:
//   Clk   : system clock, all state on the rising edge
//   Reset : asynchronous, active-low reset
//   bus   : stim_sequencer_if slave modport
//           inputs  wr_en/wr_addr/wr_delay/wr_ctrl/wr_data, len, loop,
//                   start, abort
//           outputs ctrl_n (active low), data_out, step_idx, busy, done,
//                   wr_err
// Each entry is driven for exactly delay+1 cycles. All outputs come straight
// from registers, so nothing on the input side reaches an output within a
// cycle.
// ---------------------------------------------------------------------------
module stim_sequencer
    import stim_sequencer_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int DELAY_W  = DELAY_W_DEF,
    parameter int NUM_CTRL = NUM_CTRL_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    stim_sequencer_if.slave   bus
);

    localparam int AW     = $clog2(DEPTH);
    localparam int STEP_W = DELAY_W + NUM_CTRL + DATA_W;

    localparam logic [AW:0]      LEN_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0]    IDX_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DELAY_W-1:0] DLY_ONE = {{(DELAY_W-1){1'b0}}, 1'b1};

    state_e              r_state;
    state_e              w_nextState;

    logic [DELAY_W-1:0]  r_cnt;
    logic [AW-1:0]       r_idx;
    logic [AW:0]         r_len;
    logic                r_loop;
    logic [NUM_CTRL-1:0] r_ctrlN;
    logic [DATA_W-1:0]   r_data;
    logic                r_busy;
    logic                r_done;
    logic                r_wrErr;

    logic                w_tableWe;
    logic [STEP_W-1:0]   w_wrWord;
    logic [STEP_W-1:0]   w_rdWord;
    logic [AW-1:0]       w_rdIdx;
    logic [DELAY_W-1:0]  w_rdDelay;
    logic [NUM_CTRL-1:0] w_rdCtrl;
    logic [DATA_W-1:0]   w_rdData;

    logic                w_lastStep;
    logic                w_runStart;
    logic                w_advance;
    logic                w_enterDone;
    logic                w_abort;

    // Table writes are only honoured while idle so a running script can
    // never be modified under the player.
    assign w_tableWe = bus.wr_en && (r_state == IDLE);
    assign w_wrWord  = {bus.wr_delay, bus.wr_ctrl, bus.wr_data};

    // The current index is the last one of the run when it equals len-1.
    // Comparing at len width keeps len=DEPTH working: the last index is then
    // DEPTH-1 and the wrap back to 0 happens naturally.
    assign w_lastStep = ({1'b0, r_idx} == (r_len - LEN_ONE));

    // The read port always looks at the entry that would be loaded on the
    // next advance: entry 0 when starting or wrapping, otherwise idx+1.
    assign w_rdIdx = ((r_state == PLAY) && !w_lastStep) ? (r_idx + IDX_ONE) : '0;

    assign {w_rdDelay, w_rdCtrl, w_rdData} = w_rdWord;

    stim_sequencer_table #(
        .DEPTH (DEPTH),
        .WIDTH (STEP_W),
        .AW    (AW)
    ) u_table (
        .i_clk    (Clk),
        .i_we     (w_tableWe),
        .i_wrAddr (bus.wr_addr),
        .i_wrWord (w_wrWord),
        .i_rdAddr (w_rdIdx),
        .o_rdWord (w_rdWord)
    );

    // State register. Reset kills any playback immediately.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus the one-hot datapath commands derived from it.
    // abort has priority over everything, including a simultaneous start.
    // A zero-length start goes straight to DONE so the caller still sees a
    // completion pulse without the player ever becoming busy.
    always_comb begin
        w_nextState = r_state;
        w_runStart  = 1'b0;
        w_advance   = 1'b0;
        w_enterDone = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (bus.len != '0) begin
                        w_nextState = PLAY;
                        w_runStart  = 1'b1;
                    end else begin
                        w_nextState = DONE;
                        w_enterDone = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (bus.abort) begin
                    w_nextState = IDLE;
                    w_abort     = 1'b1;
                end else if (r_cnt == '0) begin
                    if (w_lastStep && !r_loop) begin
                        w_nextState = DONE;
                        w_enterDone = 1'b1;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            DONE: begin
                w_nextState = IDLE;
                w_abort     = bus.abort;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: hold counter, index, latched run parameters and the output
    // registers. On start the entry-0 values are loaded in the same edge so
    // the first step appears one edge after start. When an entry's counter
    // reaches zero the next entry (or entry 0 on a wrap) is loaded, which
    // gives each entry exactly delay+1 cycles with no gap between entries.
    // Finishing holds the last controls and switch word; aborting releases
    // the controls but keeps the switch word.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_loop  <= 1'b0;
            r_ctrlN <= '1;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wrErr <= 1'b0;
        end else begin
            r_done  <= w_enterDone;
            r_wrErr <= bus.wr_en && (r_state != IDLE);
            if (w_runStart) begin
                r_len   <= bus.len;
                r_loop  <= bus.loop;
                r_idx   <= '0;
                r_cnt   <= w_rdDelay;
                r_ctrlN <= w_rdCtrl;
                r_data  <= w_rdData;
                r_busy  <= 1'b1;
            end else if (w_abort) begin
                r_ctrlN <= '1;
                r_busy  <= 1'b0;
            end else if (w_advance) begin
                r_idx   <= w_rdIdx;
                r_cnt   <= w_rdDelay;
                r_ctrlN <= w_rdCtrl;
                r_data  <= w_rdData;
            end else if (w_enterDone) begin
                r_busy  <= 1'b0;
            end else if (r_state == PLAY) begin
                r_cnt   <= r_cnt - DLY_ONE;
            end
        end
    end

    assign bus.ctrl_n   = r_ctrlN;
    assign bus.data_out = r_data;
    assign bus.step_idx = r_idx;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.wr_err   = r_wrErr;

endmodule

// File: tb/tb_stim_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stim_sequencer
// Self-checking bench for stim_sequencer at the default parameters. A
// behavioural model keeps its own copy of the table and expands a run into
// the per-cycle list of expected {busy, done, step_idx, ctrl_n, data_out}.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stim_sequencer;

    logic Clk;
    logic Reset;

    stim_sequencer_if #(
        .DATA_W(16), .DEPTH(16), .DELAY_W(8), .NUM_CTRL(3)
    ) bus ();

    stim_sequencer #(
        .DATA_W(16), .DEPTH(16), .DELAY_W(8), .NUM_CTRL(3)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  mDelay [16];
    logic [2:0]  mCtrl  [16];
    logic [15:0] mData  [16];
    logic [24:0] expQ [$];

    logic [24:0] obs;
    assign obs = {bus.busy, bus.done, bus.step_idx, bus.ctrl_n, bus.data_out};

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Guard against a hung simulation.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [24:0] vec(input logic b, input logic d,
                                        input logic [3:0] idx,
                                        input logic [2:0] c,
                                        input logic [15:0] w);
        return {b, d, idx, c, w};
    endfunction

    // Expands a run of n steps, repeated reps times, into one expected
    // output word per cycle. With withEnd a non-loop completion is appended:
    // one done cycle holding the last entry, then the idle cycle after it.
    function automatic void modelRun(input int n, input int reps, input bit withEnd);
        expQ.delete();
        for (int r = 0; r < reps; r++) begin
            for (int s = 0; s < n; s++) begin
                for (int c = 0; c <= int'(mDelay[s]); c++) begin
                    expQ.push_back(vec(1'b1, 1'b0, 4'(s), mCtrl[s], mData[s]));
                end
            end
        end
        if (withEnd) begin
            expQ.push_back(vec(1'b0, 1'b1, 4'(n-1), mCtrl[n-1], mData[n-1]));
            expQ.push_back(vec(1'b0, 1'b0, 4'(n-1), mCtrl[n-1], mData[n-1]));
        end
    endfunction

    task automatic applyClock();
        @(posedge Clk);
        #1;
    endtask

    // Writes one table entry (only used while the player is idle) and
    // mirrors it into the model.
    task automatic applyWrite(input int a, input logic [7:0] d,
                              input logic [2:0] c, input logic [15:0] w);
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 4'(a);
        bus.wr_delay = d;
        bus.wr_ctrl  = c;
        bus.wr_data  = w;
        applyClock();
        bus.wr_en    = 1'b0;
        mDelay[a] = d;
        mCtrl[a]  = c;
        mData[a]  = w;
    endtask

    task automatic applyStimulus(input int n, input bit lp);
        bus.len   = 5'(n);
        bus.loop  = lp;
        bus.start = 1'b1;
        applyClock();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        Reset     = 1'b0;
        bus.start = 1'b1;
        bus.len   = 5'd3;
        applyClock();
        applyClock();
        checks++;
        if (obs !== vec(1'b0, 1'b0, 4'd0, 3'b111, 16'h0000)) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h want %h", obs,
                     vec(1'b0, 1'b0, 4'd0, 3'b111, 16'h0000));
        end
        checks++;
        if (bus.wr_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_wr_err got %b want 0", bus.wr_err);
        end
        bus.start = 1'b0;
        Reset     = 1'b1;
        applyClock();
        applyClock();
        checks++;
        if (obs !== vec(1'b0, 1'b0, 4'd0, 3'b111, 16'h0000)) begin
            errors++;
            $display("[TB] FAIL reset_idle got %h want %h", obs,
                     vec(1'b0, 1'b0, 4'd0, 3'b111, 16'h0000));
        end
    endtask

    task automatic test_basic();
        applyWrite(0, 8'd1, 3'b110, 16'h0003);
        applyWrite(1, 8'd3, 3'b101, 16'h000F);
        applyWrite(2, 8'd0, 3'b011, 16'h00F0);
        checks++;
        if (bus.wr_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_idle_write_err got %b want 0", bus.wr_err);
        end
        modelRun(3, 1, 1'b1);
        applyStimulus(3, 1'b0);
        foreach (expQ[i]) begin
            checks++;
            if (obs !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL basic_cycle%0d got %h want %h", i, obs, expQ[i]);
            end
            applyClock();
        end
    endtask

    task automatic test_loop();
        modelRun(3, 2, 1'b0);
        applyStimulus(3, 1'b1);
        foreach (expQ[i]) begin
            checks++;
            if (obs !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL loop_cycle%0d got %h want %h", i, obs, expQ[i]);
            end
            applyClock();
        end
        checks++;
        if (obs !== vec(1'b1, 1'b0, 4'd0, 3'b110, 16'h0003)) begin
            errors++;
            $display("[TB] FAIL loop_third_wrap got %h want %h", obs,
                     vec(1'b1, 1'b0, 4'd0, 3'b110, 16'h0003));
        end
        bus.abort = 1'b1;
        applyClock();
        bus.abort = 1'b0;
        checks++;
        if (obs !== vec(1'b0, 1'b0, 4'd0, 3'b111, 16'h0003)) begin
            errors++;
            $display("[TB] FAIL loop_abort got %h want %h", obs,
                     vec(1'b0, 1'b0, 4'd0, 3'b111, 16'h0003));
        end
        applyClock();
        checks++;
        if (obs !== vec(1'b0, 1'b0, 4'd0, 3'b111, 16'h0003)) begin
            errors++;
            $display("[TB] FAIL loop_after_abort got %h want %h", obs,
                     vec(1'b0, 1'b0, 4'd0, 3'b111, 16'h0003));
        end
    endtask

    task automatic test_start_abort();
        bus.len   = 5'd3;
        bus.loop  = 1'b0;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        applyClock();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs !== vec(1'b0, 1'b0, 4'd0, 3'b111, 16'h0003)) begin
                errors++;
                $display("[TB] FAIL idle_start_abort%0d got %h want %h", k, obs,
                         vec(1'b0, 1'b0, 4'd0, 3'b111, 16'h0003));
            end
            applyClock();
        end
        applyStimulus(3, 1'b0);
        checks++;
        if (obs !== vec(1'b1, 1'b0, 4'd0, 3'b110, 16'h0003)) begin
            errors++;
            $display("[TB] FAIL play_first got %h want %h", obs,
                     vec(1'b1, 1'b0, 4'd0, 3'b110, 16'h0003));
        end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        applyClock();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checks++;
        if (obs !== vec(1'b0, 1'b0, 4'd0, 3'b111, 16'h0003)) begin
            errors++;
            $display("[TB] FAIL play_start_abort got %h want %h", obs,
                     vec(1'b0, 1'b0, 4'd0, 3'b111, 16'h0003));
        end
        for (int k = 0; k < 3; k++) begin
            applyClock();
            checks++;
            if ({bus.busy, bus.done} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL play_abort_no_done%0d got busy/done %b want 00",
                         k, {bus.busy, bus.done});
            end
        end
    endtask

    task automatic test_len_zero();
        applyStimulus(0, 1'b0);
        checks++;
        if (obs !== vec(1'b0, 1'b1, 4'd0, 3'b111, 16'h0003)) begin
            errors++;
            $display("[TB] FAIL len0_done got %h want %h", obs,
                     vec(1'b0, 1'b1, 4'd0, 3'b111, 16'h0003));
        end
        applyClock();
        checks++;
        if (obs !== vec(1'b0, 1'b0, 4'd0, 3'b111, 16'h0003)) begin
            errors++;
            $display("[TB] FAIL len0_after got %h want %h", obs,
                     vec(1'b0, 1'b0, 4'd0, 3'b111, 16'h0003));
        end
    endtask

    task automatic test_wr_err();
        applyStimulus(3, 1'b0);
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 4'd1;
        bus.wr_delay = 8'd5;
        bus.wr_ctrl  = 3'b000;
        bus.wr_data  = 16'hDEAD;
        applyClock();
        bus.wr_en = 1'b0;
        checks++;
        if (bus.wr_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wr_err_pulse got %b want 1", bus.wr_err);
        end
        checks++;
        if (obs !== vec(1'b1, 1'b0, 4'd0, 3'b110, 16'h0003)) begin
            errors++;
            $display("[TB] FAIL wr_err_play got %h want %h", obs,
                     vec(1'b1, 1'b0, 4'd0, 3'b110, 16'h0003));
        end
        applyClock();
        checks++;
        if (bus.wr_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr_err_single got %b want 0", bus.wr_err);
        end
        bus.abort = 1'b1;
        applyClock();
        bus.abort = 1'b0;
        applyClock();
        modelRun(3, 1, 1'b1);
        applyStimulus(3, 1'b0);
        foreach (expQ[i]) begin
            checks++;
            if (obs !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL wr_err_replay%0d got %h want %h", i, obs, expQ[i]);
            end
            applyClock();
        end
    endtask

    task automatic test_full_depth();
        for (int a = 0; a < 16; a++) begin
            applyWrite(a, 8'd0, 3'($urandom_range(0, 7)), 16'($urandom));
        end
        modelRun(16, 1, 1'b1);
        applyStimulus(16, 1'b0);
        foreach (expQ[i]) begin
            checks++;
            if (obs !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL full_depth%0d got %h want %h", i, obs, expQ[i]);
            end
            applyClock();
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 4; it++) begin
            for (int a = 0; a < 16; a++) begin
                applyWrite(a, 8'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                           16'($urandom));
            end
            n = int'($urandom_range(1, 16));
            modelRun(n, 1, 1'b1);
            applyStimulus(n, 1'b0);
            foreach (expQ[i]) begin
                checks++;
                if (obs !== expQ[i]) begin
                    errors++;
                    $display("[TB] FAIL random%0d_len%0d_cycle%0d got %h want %h",
                             it, n, i, obs, expQ[i]);
                end
                applyClock();
            end
        end
        n = int'($urandom_range(1, 16));
        modelRun(n, 2, 1'b0);
        applyStimulus(n, 1'b1);
        foreach (expQ[i]) begin
            checks++;
            if (obs !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL random_loop_len%0d_cycle%0d got %h want %h",
                         n, i, obs, expQ[i]);
            end
            applyClock();
        end
        bus.abort = 1'b1;
        applyClock();
        bus.abort = 1'b0;
        checks++;
        if (obs !== vec(1'b0, 1'b0, 4'd0, 3'b111, mData[0])) begin
            errors++;
            $display("[TB] FAIL random_loop_abort got %h want %h", obs,
                     vec(1'b0, 1'b0, 4'd0, 3'b111, mData[0]));
        end
        applyClock();
    endtask

    initial begin
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_delay = '0;
        bus.wr_ctrl  = '0;
        bus.wr_data  = '0;
        bus.len      = '0;
        bus.loop     = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        Reset        = 1'b0;
        #1;
        $display("[TB] starting stim_sequencer bench");
        test_reset();
        test_basic();
        test_loop();
        test_start_abort();
        test_len_zero();
        test_wr_err();
        test_full_depth();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
